data_seg_arbiter: RTL and testbench

//  Shares the two data segments of the segmented memory between two requesters:
//  the pipeline MEM stage (req 0) and the result/char scanner (req 1).

---
 rtl/data_seg_arbiter.sv | 127 ++++++++++++
 tb/tb_data_seg_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/data_seg_arbiter.sv
// Two-requester arbiter for the 16-bit preload and 8-bit result data segments.
// Round-robin with bounded locked bursts, range checking and a 1-cycle read path.
module data_seg_arbiter #(
    parameter int WIDTH     = 36,
    parameter int MAX_BURST = 4,
    parameter int DEPTH16   = 102,
    parameter int DEPTH8    = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req,
    input  logic [1:0]            lock,
    input  logic [1:0]            seg,
    input  logic [1:0]            we_in,
    input  logic [1:0][WIDTH-1:0] addr,
    input  logic [1:0][15:0]      wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            rvalid,
    output logic [1:0]            rerr,
    output logic [15:0]           rdata,
    output logic [1:0]            mem_we,
    output logic [WIDTH-1:0]      mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rd16,
    input  logic [7:0]            mem_rd8
);

    localparam int CW = $clog2(MAX_BURST) + 1;
    localparam logic [CW-1:0] LIM = CW'(MAX_BURST - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]    state;
    logic          rr_ptr;
    logic [CW-1:0] burst_cnt;

    logic          keep;
    logic          any;
    logic          win;
    logic [CW-1:0] cnt_nxt;
    logic          sel_seg;
    logic          sel_we;
    logic          in_range;
    logic [15:0]   rd_sel;

    // Owner keeps the bus only while it still requests and locks, up to the burst limit.
    always_comb begin
        keep = 1'b0;
        if (rst) begin
            case (state)
                OWN0:    keep = lock[0] & req[0] & (burst_cnt < LIM);
                OWN1:    keep = lock[1] & req[1] & (burst_cnt < LIM);
                default: keep = 1'b0;
            endcase
        end
    end

    always_comb begin
        any     = 1'b0;
        win     = 1'b0;
        cnt_nxt = '0;
        if (rst) begin
            if (keep) begin
                any     = 1'b1;
                win     = (state == OWN1);
                cnt_nxt = burst_cnt + CW'(1);
            end else if (req != 2'b00) begin
                any = 1'b1;
                unique case (1'b1)
                    (req == 2'b01): win = 1'b0;
                    (req == 2'b10): win = 1'b1;
                    default:        win = rr_ptr;
                endcase
            end
        end
    end

    always_comb begin
        sel_seg  = seg[win];
        sel_we   = we_in[win];
        in_range = sel_seg ? (addr[win] < WIDTH'(DEPTH8))
                           : (addr[win] < WIDTH'(DEPTH16));
        rd_sel   = sel_seg ? {8'h00, mem_rd8} : mem_rd16;
    end

    always_comb begin
        gnt       = 2'b00;
        mem_we    = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        if (any) begin
            gnt       = win ? 2'b10 : 2'b01;
            mem_addr  = addr[win];
            mem_wdata = wdata[win];
            if (sel_we && in_range)
                mem_we = sel_seg ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
            rvalid    <= 2'b00;
            rerr      <= 2'b00;
            rdata     <= '0;
        end else begin
            if (any) begin
                state     <= win ? OWN1 : OWN0;
                rr_ptr    <= ~win;
                burst_cnt <= cnt_nxt;
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
            rvalid <= (any && !sel_we) ? gnt : 2'b00;
            rerr   <= (any && !in_range) ? gnt : 2'b00;
            // Out-of-range reads return zero rather than whatever the slot shows.
            if (any && !sel_we)
                rdata <= in_range ? rd_sel : 16'h0000;
        end
    end

endmodule

// File: tb/tb_data_seg_arbiter.sv
// Directed bench for data_seg_arbiter with a small two-segment memory model.
// Inputs change 1ns after posedge; comb outputs checked at negedge.
module tb_data_seg_arbiter;

    localparam int W = 36;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req, lock, seg, we_in;
    logic [1:0][W-1:0] addr;
    logic [1:0][15:0]  wdata;
    logic [1:0]        gnt, rvalid, rerr, mem_we;
    logic [15:0]       rdata, mem_wdata, mem_rd16;
    logic [W-1:0]      mem_addr;
    logic [7:0]        mem_rd8;

    logic [15:0] m16 [0:127];
    logic [7:0]  m8  [0:127];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    data_seg_arbiter #(
        .WIDTH(W), .MAX_BURST(4), .DEPTH16(102), .DEPTH8(100)
    ) dut (
        .clk(clk), .rst(rst),
        .req(req), .lock(lock), .seg(seg), .we_in(we_in),
        .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rerr(rerr), .rdata(rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd16(mem_rd16), .mem_rd8(mem_rd8)
    );

    assign mem_rd16 = m16[mem_addr[6:0]];
    assign mem_rd8  = m8[mem_addr[6:0]];

    always @(posedge clk) begin
        if (mem_we[0]) m16[mem_addr[6:0]] <= mem_wdata;
        if (mem_we[1]) m8[mem_addr[6:0]]  <= mem_wdata[7:0];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] l,
                         input logic [1:0] s, input logic [1:0] w,
                         input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        req = r; lock = l; seg = s; we_in = w;
        addr[0] = a0; addr[1] = a1;
        wdata[0] = d0; wdata[1] = d1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            m16[i] = 16'h0;
            m8[i]  = 8'h0;
        end
        rst = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 2'b00, '0, '0, 16'h0, 16'h0);
        tick();
        tick();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_rerr", rerr, 2'b00);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_mem_we", mem_we, 2'b00);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);

        // Plain round robin: 0,1,0,1 starting with req 0.
        rst = 1'b1;
        m16[1] = 16'h1111;
        drive(2'b11, 2'b00, 2'b00, 2'b00, 36'd0, 36'd1, 16'h0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt%0d", i), gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk($sformatf("rr_rvalid%0d", i), rvalid,
                (i % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("rr_rdata%0d", i), rdata,
                (i % 2 == 0) ? 16'h0000 : 16'h1111);
        end

        // Locked burst by req 0 while req 1 waits: four grants then handover.
        drive(2'b11, 2'b01, 2'b00, 2'b00, 36'd0, 36'd1, 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("burst_gnt%0d", i), gnt, (i < 4) ? 2'b01 : 2'b10);
            tick();
        end
        drive(2'b00, 2'b00, 2'b00, 2'b00, '0, '0, 16'h0, 16'h0);
        tick();

        // Write then back-to-back read, 16-bit segment.
        drive(2'b01, 2'b00, 2'b00, 2'b01, 36'd5, '0, 16'hBEEF, 16'h0);
        @(negedge clk);
        chk("w16_gnt", gnt, 2'b01);
        chk("w16_we", mem_we, 2'b01);
        chk("w16_addr", mem_addr, 36'd5);
        chk("w16_wdata", mem_wdata, 16'hBEEF);
        tick();
        chk("w16_rvalid", rvalid, 2'b00);
        chk("w16_rerr", rerr, 2'b00);
        drive(2'b01, 2'b00, 2'b00, 2'b00, 36'd5, '0, 16'h0, 16'h0);
        @(negedge clk);
        chk("r16_gnt", gnt, 2'b01);
        tick();
        chk("r16_rvalid", rvalid, 2'b01);
        chk("r16_rdata", rdata, 16'hBEEF);

        // 8-bit segment, last valid address.
        drive(2'b10, 2'b00, 2'b10, 2'b10, '0, 36'd99, 16'h0, 16'h01A5);
        @(negedge clk);
        chk("w8_gnt", gnt, 2'b10);
        chk("w8_we", mem_we, 2'b10);
        tick();
        chk("w8_stored", m8[99], 8'hA5);
        drive(2'b10, 2'b00, 2'b10, 2'b00, '0, 36'd99, 16'h0, 16'h0);
        tick();
        chk("r8_rvalid", rvalid, 2'b10);
        chk("r8_rdata", rdata, 16'h00A5);

        // Out-of-range read on seg 1 and write on seg 0.
        m8[100] = 8'h77;
        drive(2'b10, 2'b00, 2'b10, 2'b00, '0, 36'd100, 16'h0, 16'h0);
        @(negedge clk);
        chk("oor_r_we", mem_we, 2'b00);
        tick();
        chk("oor_r_rerr", rerr, 2'b10);
        chk("oor_r_rvalid", rvalid, 2'b10);
        chk("oor_r_rdata", rdata, 16'h0);
        drive(2'b01, 2'b00, 2'b00, 2'b01, 36'd102, '0, 16'h1234, 16'h0);
        @(negedge clk);
        chk("oor_w_gnt", gnt, 2'b01);
        chk("oor_w_we", mem_we, 2'b00);
        tick();
        chk("oor_w_rerr", rerr, 2'b01);
        chk("oor_w_rvalid", rvalid, 2'b00);
        chk("oor_w_mem", m16[102], 16'h0);
        drive(2'b01, 2'b00, 2'b00, 2'b01, 36'd101, '0, 16'h5A5A, 16'h0);
        @(negedge clk);
        chk("edge_w_we", mem_we, 2'b01);
        tick();
        chk("edge_w_rerr", rerr, 2'b00);

        // Reset in the middle of a locked burst.
        drive(2'b00, 2'b00, 2'b00, 2'b00, '0, '0, 16'h0, 16'h0);
        tick();
        drive(2'b01, 2'b01, 2'b00, 2'b00, 36'd5, 36'd5, 16'h0, 16'h0);
        @(negedge clk);
        chk("mb_gnt_a", gnt, 2'b01);
        tick();
        chk("mb_rdata_a", rdata, 16'hBEEF);
        drive(2'b11, 2'b01, 2'b00, 2'b00, 36'd5, 36'd5, 16'h0, 16'h0);
        @(negedge clk);
        chk("mb_gnt_b", gnt, 2'b01);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mb_rst_gnt", gnt, 2'b00);
        chk("mb_rst_we", mem_we, 2'b00);
        tick();
        chk("mb_rst_rvalid", rvalid, 2'b00);
        chk("mb_rst_rdata", rdata, 16'h0);
        rst = 1'b1;
        drive(2'b11, 2'b00, 2'b00, 2'b00, 36'd5, 36'd5, 16'h0, 16'h0);
        @(negedge clk);
        chk("mb_after_gnt", gnt, 2'b01);
        tick();
        chk("mb_after_rvalid", rvalid, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
